// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with a programmable baud divisor, 16x oversampled receive,
// runtime frame format (5-8 data bits, optional parity, 1/2 stop bits), TX/RX FIFOs with
// valid/ready handshakes and sticky receive error flags.
module uart_fifo_core #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned OVS        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [3:0]                    frame_length,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic                          stop2,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic                          err_clr,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overrun,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    input  logic                          rx,
    output logic                          tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] OvsLast = CW'(OVS - 1);
    // Start-bit re-sample lands OVS/2-1 ticks after entry; counter is 0 on the first of those.
    localparam logic [CW-1:0] OvsHalf = CW'(OVS / 2 - 2);
    localparam logic [AW:0]   LvlFull = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh} rx_state_e;

    function automatic logic [3:0] clamp_len(input logic [3:0] fl);
        if (fl < 4'd5)      return 4'd5;
        else if (fl > 4'd8) return 4'd8;
        else                return fl;
    endfunction

    function automatic logic [7:0] len_mask(input logic [3:0] n);
        return 8'hFF >> (4'd8 - n);
    endfunction

    // ------------------------------------------------------------------ tick generator
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic             tick;

    // Divisor is captured only at wrap so a change never truncates or stretches a period.
    always_comb begin
        tick  = (cnt_q == div_q);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        div_d = tick ? divisor : div_q;
    end

    // ------------------------------------------------------------------ TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   tx_level_q, tx_level_d;
    logic          tx_push, tx_pop;

    // TX FIFO bookkeeping; a push and pop never coincide on a full FIFO.
    always_comb begin
        tx_ready   = (tx_level_q != LvlFull);
        tx_push    = tx_valid && tx_ready;
        tx_wptr_d  = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d  = tx_pop ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_level_d = tx_level_q;
        if (tx_push && !tx_pop)      tx_level_d = tx_level_q + 1'b1;
        else if (!tx_push && tx_pop) tx_level_d = tx_level_q - 1'b1;
    end

    // TX storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= tx_data;
    end

    // ------------------------------------------------------------------ TX FSM
    tx_state_e  tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [3:0] tx_len_q, tx_len_d;
    logic       tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d, tx_q, tx_d;
    logic       tx_bit_end, tx_frame_end, tx_load;
    logic [3:0] tx_new_len;
    logic [7:0] tx_new_word;

    // TX next state: each state lasts OVS ticks; frames chain with no idle gap.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_len_d     = tx_len_q;
        tx_par_d     = tx_par_q;
        tx_pen_d     = tx_pen_q;
        tx_stop2_d   = tx_stop2_q;
        tx_pop       = 1'b0;
        tx_load      = 1'b0;
        tx_frame_end = 1'b0;
        tx_bit_end   = tick && (tx_cnt_q == OvsLast);
        tx_new_len   = clamp_len(frame_length);
        tx_new_word  = tx_mem[tx_rptr_q] & len_mask(tx_new_len);

        if (tick && tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;

        unique case (tx_state_q)
            TxIdle:   tx_load = tick && (tx_level_q != '0);
            TxStart:  if (tx_bit_end) begin
                          tx_state_d = TxData;
                          tx_bit_d   = '0;
                      end
            TxData:   if (tx_bit_end) begin
                          if ({1'b0, tx_bit_q} == tx_len_q - 4'd1) begin
                              tx_state_d = tx_pen_q ? TxParity : TxStop1;
                          end else begin
                              tx_bit_d   = tx_bit_q + 1'b1;
                              tx_shift_d = tx_shift_q >> 1;
                          end
                      end
            TxParity: if (tx_bit_end) tx_state_d = TxStop1;
            TxStop1:  if (tx_bit_end) begin
                          if (tx_stop2_q) tx_state_d = TxStop2;
                          else            tx_frame_end = 1'b1;
                      end
            TxStop2:  if (tx_bit_end) tx_frame_end = 1'b1;
            default:  tx_state_d = TxIdle;
        endcase

        if (tx_frame_end) begin
            if (tx_level_q != '0) tx_load = 1'b1;
            else                  tx_state_d = TxIdle;
        end

        // Frame start: pop head and freeze the frame format for the whole frame.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = TxStart;
            tx_cnt_d   = '0;
            tx_len_d   = tx_new_len;
            tx_shift_d = tx_new_word;
            tx_par_d   = (^tx_new_word) ^ parity_type;
            tx_pen_d   = parity_en;
            tx_stop2_d = stop2;
        end

        unique case (tx_state_d)
            TxStart:  tx_d = 1'b0;
            TxData:   tx_d = tx_shift_d[0];
            TxParity: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX front end and FSM
    logic          rx_meta_q, rx_s_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [3:0]    rx_len_q, rx_len_d;
    logic          rx_pen_q, rx_pen_d, rx_ptype_q, rx_ptype_d, rx_stop2_q, rx_stop2_d;
    logic          rx_sidx_q, rx_sidx_d;
    logic          rx_sample, rx_push, par_set, frm_set;

    // RX next state: mid-bit sampling every OVS ticks after the start-bit re-sample.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_len_d   = rx_len_q;
        rx_pen_d   = rx_pen_q;
        rx_ptype_d = rx_ptype_q;
        rx_stop2_d = rx_stop2_q;
        rx_sidx_d  = rx_sidx_q;
        rx_push    = 1'b0;
        par_set    = 1'b0;
        frm_set    = 1'b0;
        rx_sample  = tick && (rx_cnt_q == OvsLast);

        if (tick && rx_state_q inside {RxData, RxParity, RxStop}) begin
            rx_cnt_d = rx_sample ? '0 : rx_cnt_q + 1'b1;
        end

        unique case (rx_state_q)
            RxIdle:     if (tick && !rx_s_q) begin
                            rx_state_d = RxStart;
                            rx_cnt_d   = '0;
                            rx_shift_d = '0;
                            rx_len_d   = clamp_len(frame_length);
                            rx_pen_d   = parity_en;
                            rx_ptype_d = parity_type;
                            rx_stop2_d = stop2;
                        end
            RxStart:    if (tick) begin
                            if (rx_cnt_q == OvsHalf) begin
                                rx_cnt_d   = '0;
                                rx_bit_d   = '0;
                                rx_state_d = rx_s_q ? RxIdle : RxData;
                            end else begin
                                rx_cnt_d = rx_cnt_q + 1'b1;
                            end
                        end
            RxData:     if (rx_sample) begin
                            rx_shift_d[rx_bit_q] = rx_s_q;
                            if ({1'b0, rx_bit_q} == rx_len_q - 4'd1) begin
                                rx_state_d = rx_pen_q ? RxParity : RxStop;
                                rx_sidx_d  = 1'b0;
                            end else begin
                                rx_bit_d = rx_bit_q + 1'b1;
                            end
                        end
            RxParity:   if (rx_sample) begin
                            par_set    = (rx_s_q != ((^rx_shift_q) ^ rx_ptype_q));
                            rx_state_d = RxStop;
                            rx_sidx_d  = 1'b0;
                        end
            RxStop:     if (rx_sample) begin
                            frm_set = !rx_s_q;
                            if (rx_stop2_q && !rx_sidx_q) begin
                                rx_sidx_d = 1'b1;
                            end else begin
                                rx_push    = 1'b1;
                                rx_state_d = rx_s_q ? RxIdle : RxWaitHigh;
                            end
                        end
            // A held-low line (break) must return high before a new start is accepted.
            RxWaitHigh: if (rx_s_q) rx_state_d = RxIdle;
            default:    rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------ RX FIFO and flags
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   rx_level_q, rx_level_d;
    logic          rx_pop, rx_wr, ovr_set;
    logic          par_q, par_d, frm_q, frm_d, ovr_q, ovr_d;

    // RX FIFO bookkeeping; a full FIFO still accepts a push when the head pops the same cycle.
    always_comb begin
        rx_valid   = (rx_level_q != '0);
        rx_pop     = rx_ready && rx_valid;
        rx_wr      = rx_push && ((rx_level_q != LvlFull) || rx_pop);
        ovr_set    = rx_push && !rx_wr;
        rx_wptr_d  = rx_wr ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d  = rx_pop ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_level_d = rx_level_q;
        if (rx_wr && !rx_pop)      rx_level_d = rx_level_q + 1'b1;
        else if (!rx_wr && rx_pop) rx_level_d = rx_level_q - 1'b1;
        // Sticky flags: a new error wins over a clear in the same cycle.
        par_d = par_set || (par_q && !err_clr);
        frm_d = frm_set || (frm_q && !err_clr);
        ovr_d = ovr_set || (ovr_q && !err_clr);
    end

    // RX storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    // Two-flop synchroniser for the asynchronous rx pin, idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // All control state; reset aborts any frame and drives tx high at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            div_q      <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_len_q   <= 4'd8;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_q       <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_len_q   <= 4'd8;
            rx_pen_q   <= 1'b0;
            rx_ptype_q <= 1'b0;
            rx_stop2_q <= 1'b0;
            rx_sidx_q  <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_len_q   <= tx_len_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_len_q   <= rx_len_d;
            rx_pen_q   <= rx_pen_d;
            rx_ptype_q <= rx_ptype_d;
            rx_stop2_q <= rx_stop2_d;
            rx_sidx_q  <= rx_sidx_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            par_q      <= par_d;
            frm_q      <= frm_d;
            ovr_q      <= ovr_d;
        end
    end

    // Output wiring.
    always_comb begin
        tx            = tx_q;
        tx_busy       = (tx_state_q != TxIdle);
        tx_level      = tx_level_q;
        rx_level      = rx_level_q;
        rx_data       = rx_valid ? rx_mem[rx_rptr_q] : 8'h00;
        rx_parity_err = par_q;
        rx_frame_err  = frm_q;
        rx_overrun    = ovr_q;
    end

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised successor to the single-frame UART top. Full-duplex UART core with:
- a programmable 16-bit baud divisor and 16x oversampled receive;
- runtime frame format: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits;
- TX and RX FIFOs with valid/ready handshakes;
- sticky parity, framing and overrun error flags.
Sits between the bus/register layer and the physical tx/rx pins.

Parameters:
- DIV_W, 16: width of divisor input.
- FIFO_DEPTH, 8: entries per FIFO. Power of two, ≥2.
- OVS, 16: oversampling ticks per bit. Even, ≥4.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- divisor, input, DIV_W: oversample tick every divisor+1 clocks.
- frame_length, input, 4: data bits. Values <5 treated as 5; values >8 treated as 8.
- parity_en, input, 1: parity bit present.
- parity_type, input, 1: 0 = even, 1 = odd.
- stop2, input, 1: two stop bits.
- tx_data, input, 8: TX FIFO write data.
- tx_valid, input, 1: TX write request.
- tx_ready, output, 1: TX FIFO not full.
- rx_data, output, 8: RX FIFO head, first-word fall-through; unused upper bits are 0.
- rx_valid, output, 1: RX FIFO not empty.
- rx_ready, input, 1: RX pop request.
- err_clr, input, 1: clears all sticky error flags.
- rx_parity_err, output, 1: sticky.
- rx_frame_err, output, 1: sticky.
- rx_overrun, output, 1: sticky.
- tx_busy, output, 1: frame in flight.
- tx_level, output, $clog2(FIFO_DEPTH)+1: TX FIFO occupancy.
- rx_level, output, $clog2(FIFO_DEPTH)+1: RX FIFO occupancy.
- rx, input, 1: serial in, asynchronous to clk.
- tx, output, 1: serial out, idles high.

Behaviour:
- Reset (async assert, sync release): tx=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, levels=0, all flags=0. Both FIFOs emptied, both FSMs to IDLE, tick counter=0, rx synchroniser=1. Reset mid-frame aborts the frame; tx goes high immediately.
- Tick generator:
  - Counter runs 0..divisor; tick is a one-clock pulse when counter==divisor, then counter returns to 0.
  - A divisor change takes effect at the next wrap.
  - divisor=0 gives a tick every clock.
- Handshakes:
  - A transfer occurs on a rising clk edge with valid&&ready.
  - tx_valid while !tx_ready is ignored, no error.
  - RX pop while empty is ignored.
- Frame format: config is sampled at frame start (TX pop / RX start acceptance) and held for the frame. Data is sent LSB first. Parity covers only frame_length data bits: even parity makes the total ones even; odd makes it odd.
- TX FSM, states IDLE, START, DATA, PARITY, STOP1, STOP2:
  - IDLE: on a tick with FIFO non-empty, pop the head, assert tx_busy, enter START.
  - Each state holds tx for exactly OVS ticks.
  - PARITY is skipped when !parity_en; STOP2 is skipped when !stop2.
  - After the last stop bit: if FIFO non-empty, go directly to START of the next frame with no idle gap. Otherwise go to IDLE and deassert tx_busy.
- RX front-end: 2-flop synchroniser on rx.
- RX FSM, states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH:
  - IDLE: first tick with rx_s=0 enters START.
  - START: at the tick OVS/2-1 after entry, re-sample. If 1 → false start, return to IDLE. If 0 → DATA.
  - DATA, PARITY, STOP: sample every OVS ticks (mid-bit). Data bits shift into LSB-first positions.
  - Parity mismatch sets rx_parity_err.
  - Any sampled stop bit = 0 sets rx_frame_err. With stop2, both stop bits are checked.
  - Push occurs at the final stop sample; the word is pushed even when erroneous.
  - On push with RX FIFO full and no simultaneous pop: word dropped, rx_overrun set.
  - Full with a simultaneous pop: both happen, no overrun.
  - After the final stop sample: if rx_s=1 → IDLE, else → WAIT_HIGH. WAIT_HIGH waits for rx_s=1, then → IDLE (break/low line never retriggers).
- Sticky flags: set has priority over err_clr in the same cycle.
- FIFOs:
  - Level increments on push-only, decrements on pop-only, unchanged on push+pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push+pop on a full TX FIFO cannot occur, because tx_ready=0 blocks the push.
  - rx_data updates the cycle after a pop.
- Latency: tx falls (start bit) 1 clk after the tick following the tx_valid&&tx_ready cycle. rx_valid rises 1 clk after the final stop-sample tick.

Test Plan:
- Loopback tx→rx, divisor=0, 8N1 (frame_length=8, parity_en=0, stop2=0), write 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 16 clks; rx_data=0xA5; all flags 0.
- frame_length=7, parity_en=1, parity_type=1, write 0x41 → 7 data bits 1,0,0,0,0,0,1, parity bit 1; loopback rx_data=0x41, no parity error. Then force the bus parity bit to 0 → rx_parity_err=1, word still pushed.
- FIFO_DEPTH=4, write 6 words 0x10..0x15 back-to-back → tx_ready deasserts at tx_level=4 while words 0x10..0x13 wait; no idle gap between frames. With rx_ready=0 → rx_level=4, head=0x10, rx_overrun=1.
- Drive a frame with stop bit 0, then hold rx low for 40 bit-times → rx_frame_err=1, one word pushed, no further frames until rx returns high. Then pulse err_clr → all flags 0.
- rx low glitch for 4 ticks (divisor=3) → no frame received, rx_valid stays 0.
- Assert reset (0) mid-DATA of a TX frame → tx=1 within the same cycle, tx_level=0, tx_busy=0. After release, a new 0x3C frame is transmitted correctly.
